serial_adder_sub: RTL and testbench
===================================

SERIAL_ADDER_SUB -- requirements
Module: serial_adder_sub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have port start, input, 1, request to begin an operation.
REQ-005 The block SHALL have port mode, input, 1, operation select: 0 = add (A+B+Cin), 1 = subtract (A-B-Cin, Cin as borrow-in).
REQ-006 The block SHALL have port A, input, WIDTH, first operand.
REQ-007 The block SHALL have port B, input, WIDTH, second operand.
REQ-008 The block SHALL have port Cin, input, 1, carry-in for add and borrow-in for subtract.
REQ-009 The block SHALL have port S, output, WIDTH, registered result.
REQ-010 The block SHALL have port Cout, output, 1, raw carry out of the MSB; in subtract, 1 means no borrow.
REQ-011 The block SHALL have port V, output, 1, two's-complement signed overflow.
REQ-012 The block SHALL have port busy, output, 1, high while an operation is in progress.
REQ-013 The block SHALL have port done, output, 1, one-cycle pulse marking a valid new result.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-015 In IDLE or DONE, start=1 SHALL do all of the following on the same edge:
- latch A;
- latch B, or ~B when mode=1;
- load the carry register with Cin XOR mode;
- clear the bit counter;
- go to RUN.
REQ-016 In RUN, each edge SHALL add exactly one bit, LSB first, using one 1-bit full-adder cell (sum = a^b^c, carry = ab|ac|bc) and the carry register.
REQ-017 Each RUN edge SHALL shift the sum bit into an internal result shift register and update the carry register.
REQ-018 RUN SHALL last exactly WIDTH edges.
REQ-019 On the WIDTH-th RUN edge the block SHALL:
- load S from the completed result;
- load Cout with the final carry;
- load V with (carry into MSB) XOR (carry out of MSB);
- go to DONE.
REQ-020 The done output SHALL be 1 only while in DONE, so it is high for exactly one cycle, starting WIDTH edges after the edge that sampled start.
REQ-021 DONE SHALL go to IDLE on the next edge unless start=1, in which case a new operation begins back-to-back with no idle cycle.
REQ-022 The busy output SHALL be 1 exactly while in RUN.
REQ-023 The block SHALL ignore start while in RUN; operands and mode SHALL NOT be re-sampled mid-operation.
REQ-024 Changes on A, B, mode or Cin after the start edge SHALL NOT affect the running operation.
REQ-025 S, Cout and V SHALL hold their last values from the end of one operation until the final edge of the next operation.
REQ-026 Results SHALL be modulo 2^WIDTH; no output width SHALL exceed what is listed above.
REQ-027 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap within an operation.

Reset
REQ-028 While rst_n=0 at a rising edge, the block SHALL go to IDLE and clear S, Cout, V, busy, done, the carry register, the bit counter and the shift register to 0.
REQ-029 Reset SHALL take priority over start.
REQ-030 Reset in RUN SHALL abort the operation with no done pulse and no S update.
REQ-031 After reset is released, the first start SHALL behave as a normal start from IDLE.

Verification (WIDTH=8)
REQ-032 Bench SHALL cover add overflow: start with mode=0, A=8'hFF, B=8'h01, Cin=0 -> done after 8 edges, S=8'h00, Cout=1, V=0, busy high for 8 cycles.
REQ-033 Bench SHALL cover signed add overflow: mode=0, A=8'h7F, B=8'h01, Cin=0 -> S=8'h80, Cout=0, V=1.
REQ-034 Bench SHALL cover subtract with borrow-in: mode=1, A=8'h05, B=8'h03, Cin=1 -> S=8'h01, Cout=1, V=0.
REQ-035 Bench SHALL cover subtract overflow: mode=1, A=8'h80, B=8'h01, Cin=0 -> S=8'h7F, Cout=1, V=1.
REQ-036 Bench SHALL cover back-to-back and ignored start:
- start held during the DONE cycle -> new RUN begins immediately;
- start pulsed mid-RUN with new operands -> ignored, and the result reflects the first operands.
REQ-037 Bench SHALL cover reset mid-operation: rst_n=0 on the 4th RUN edge -> state IDLE; S, Cout, V, busy, done all 0; no done pulse; the next start completes correctly.
REQ-038 Bench SHALL run an exhaustive or random compare of S, Cout and V against a reference model for all mode/Cin combinations.

Source files
------------

// File: rtl/serial_adder_sub.sv
// serial_adder_sub: bit-serial add/subtract, one full-adder cell, LSB first, WIDTH cycles per operation
module serial_adder_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh;
  logic [CW-1:0] cnt;
  logic c, sum, cy, last;
  assign sum  = a_sh[0] ^ b_sh[0] ^ c;
  assign cy   = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
  assign last = cnt == CW'(WIDTH - 1);
  assign busy = state == RUN;
  assign done = state == DONE;
  // state register
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_nx;
  // RUN ignores start; IDLE and DONE both accept it, giving back-to-back operation from DONE
  always_comb
    state_nx = (state == RUN) ? (last ? DONE : RUN) : (start ? RUN : IDLE);
  // operand load on start, then one full-adder step per RUN edge; outputs update only on the last step
  always_ff @(posedge clk)
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      r_sh <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      S    <= '0;
      Cout <= 1'b0;
      V    <= 1'b0;
    end else if (state != RUN && start) begin
      a_sh <= A;
      b_sh <= mode ? ~B : B;
      c    <= Cin ^ mode;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      r_sh <= {sum, r_sh[WIDTH-1:1]};
      c    <= cy;
      cnt  <= cnt + CW'(1);
      if (last) begin
        S    <= {sum, r_sh[WIDTH-1:1]};
        Cout <= cy;
        V    <= c ^ cy;
      end
    end
endmodule

// File: tb/tb_serial_adder_sub.sv
// tb_serial_adder_sub: directed and randomized self-checking bench for serial_adder_sub
module tb_serial_adder_sub;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode = 1'b0, Cin = 1'b0;
  logic [7:0] A = '0, B = '0, S;
  logic Cout, V, busy, done;
  int tests = 0, fails = 0;

  serial_adder_sub #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .A(A), .B(B), .Cin(Cin),
    .S(S), .Cout(Cout), .V(V), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic wait_done(output int cycles, output int bc);
    cycles = 0;
    bc = 0;
    while (done !== 1'b1 && cycles < 40) begin
      if (busy === 1'b1) bc++;
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic run_op(input logic m, input logic [7:0] a, input logic [7:0] b, input logic ci,
                        output int cycles, output int bc);
    start = 1'b1; mode = m; A = a; B = b; Cin = ci;
    @(negedge clk);
    start = 1'b0; mode = ~m; A = ~a; B = ~b; Cin = ~ci;
    wait_done(cycles, bc);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({busy, done, Cout, V, S} !== 12'h000) begin
      fails++;
      $display("FAIL reset_state got %h exp 000", {busy, done, Cout, V, S});
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if ({busy, done} !== 2'b00) begin
      fails++;
      $display("FAIL idle_after_reset got %b exp 00", {busy, done});
    end
  endtask

  task automatic test_add_overflow;
    int cy, bc;
    run_op(1'b0, 8'hFF, 8'h01, 1'b0, cy, bc);
    tests++;
    if (cy !== 8) begin fails++; $display("FAIL add_latency got %0d exp 8", cy); end
    tests++;
    if (bc !== 8) begin fails++; $display("FAIL add_busy_cycles got %0d exp 8", bc); end
    tests++;
    if ({done, Cout, V, S} !== {1'b1, 1'b1, 1'b0, 8'h00}) begin
      fails++;
      $display("FAIL add_ff_01 got %h exp %h", {done, Cout, V, S}, {1'b1, 1'b1, 1'b0, 8'h00});
    end
    @(negedge clk);
    tests++;
    if ({busy, done, Cout, V, S} !== {1'b0, 1'b0, 1'b1, 1'b0, 8'h00}) begin
      fails++;
      $display("FAIL done_one_cycle_hold got %h exp %h", {busy, done, Cout, V, S}, {4'b0010, 8'h00});
    end
  endtask

  task automatic test_signed_add_overflow;
    int cy, bc;
    run_op(1'b0, 8'h7F, 8'h01, 1'b0, cy, bc);
    tests++;
    if ({done, Cout, V, S} !== {1'b1, 1'b0, 1'b1, 8'h80}) begin
      fails++;
      $display("FAIL add_7f_01 got %h exp %h", {done, Cout, V, S}, {1'b1, 1'b0, 1'b1, 8'h80});
    end
    @(negedge clk);
    run_op(1'b0, 8'h12, 8'h34, 1'b1, cy, bc);
    tests++;
    if ({done, Cout, V, S} !== {1'b1, 1'b0, 1'b0, 8'h47}) begin
      fails++;
      $display("FAIL add_carry_in got %h exp %h", {done, Cout, V, S}, {1'b1, 1'b0, 1'b0, 8'h47});
    end
    @(negedge clk);
  endtask

  task automatic test_subtract;
    int cy, bc;
    run_op(1'b1, 8'h05, 8'h03, 1'b1, cy, bc);
    tests++;
    if ({done, Cout, V, S} !== {1'b1, 1'b1, 1'b0, 8'h01}) begin
      fails++;
      $display("FAIL sub_borrow_in got %h exp %h", {done, Cout, V, S}, {1'b1, 1'b1, 1'b0, 8'h01});
    end
    @(negedge clk);
    run_op(1'b1, 8'h80, 8'h01, 1'b0, cy, bc);
    tests++;
    if ({done, Cout, V, S} !== {1'b1, 1'b1, 1'b1, 8'h7F}) begin
      fails++;
      $display("FAIL sub_overflow got %h exp %h", {done, Cout, V, S}, {1'b1, 1'b1, 1'b1, 8'h7F});
    end
    @(negedge clk);
    run_op(1'b1, 8'h03, 8'h05, 1'b0, cy, bc);
    tests++;
    if ({done, Cout, V, S} !== {1'b1, 1'b0, 1'b0, 8'hFE}) begin
      fails++;
      $display("FAIL sub_borrow_out got %h exp %h", {done, Cout, V, S}, {1'b1, 1'b0, 1'b0, 8'hFE});
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int cy, bc;
    run_op(1'b0, 8'h10, 8'h20, 1'b0, cy, bc);
    start = 1'b1; mode = 1'b0; A = 8'h01; B = 8'h02; Cin = 1'b1;
    @(negedge clk);
    start = 1'b0; A = 8'hAA; B = 8'h55;
    tests++;
    if ({busy, S} !== {1'b1, 8'h30}) begin
      fails++;
      $display("FAIL b2b_no_idle_hold got %h exp %h", {busy, S}, {1'b1, 8'h30});
    end
    wait_done(cy, bc);
    tests++;
    if ({cy[7:0], done, Cout, V, S} !== {8'd8, 1'b1, 1'b0, 1'b0, 8'h04}) begin
      fails++;
      $display("FAIL b2b_second_op got %h exp %h", {cy[7:0], done, Cout, V, S}, {8'd8, 3'b100, 8'h04});
    end
    @(negedge clk);
  endtask

  task automatic test_ignored_start;
    int cy, bc;
    start = 1'b1; mode = 1'b0; A = 8'h40; B = 8'h41; Cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; mode = 1'b1; A = 8'h01; B = 8'h01; Cin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cy, bc);
    tests++;
    if ({cy[7:0], done, Cout, V, S} !== {8'd6, 1'b1, 1'b0, 1'b1, 8'h81}) begin
      fails++;
      $display("FAIL ignored_start got %h exp %h", {cy[7:0], done, Cout, V, S}, {8'd6, 3'b101, 8'h81});
    end
    @(negedge clk);
    tests++;
    if ({busy, done} !== 2'b00) begin
      fails++;
      $display("FAIL ignored_start_no_rerun got %b exp 00", {busy, done});
    end
  endtask

  task automatic test_reset_mid_op;
    int cy, bc, pulses;
    start = 1'b1; mode = 1'b0; A = 8'h33; B = 8'h22; Cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if ({busy, done, Cout, V, S} !== 12'h000) begin
      fails++;
      $display("FAIL reset_mid_op got %h exp 000", {busy, done, Cout, V, S});
    end
    rst_n = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) pulses++;
    end
    tests++;
    if (pulses !== 0) begin fails++; $display("FAIL reset_abort_activity got %0d exp 0", pulses); end
    run_op(1'b0, 8'h33, 8'h22, 1'b0, cy, bc);
    tests++;
    if ({cy[7:0], done, Cout, V, S} !== {8'd8, 1'b1, 1'b0, 1'b0, 8'h55}) begin
      fails++;
      $display("FAIL after_reset_op got %h exp %h", {cy[7:0], done, Cout, V, S}, {8'd8, 3'b100, 8'h55});
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    int cy, bc;
    logic [7:0] a, b, r;
    logic [8:0] full;
    logic vx;
    for (int k = 0; k < 4; k++)
      for (int n = 0; n < 16; n++) begin
        a = 8'($urandom);
        b = 8'($urandom);
        if (k[1]) begin
          full = {1'b0, a} + {1'b0, ~b} + {8'd0, ~k[0]};
          r = full[7:0];
          vx = (a[7] != b[7]) && (r[7] != a[7]);
        end else begin
          full = {1'b0, a} + {1'b0, b} + {8'd0, k[0]};
          r = full[7:0];
          vx = (a[7] == b[7]) && (r[7] != a[7]);
        end
        run_op(k[1], a, b, k[0], cy, bc);
        tests++;
        if ({done, Cout, V, S} !== {1'b1, full[8], vx, r}) begin
          fails++;
          $display("FAIL random m=%0d cin=%0d a=%h b=%h got %h exp %h", k[1], k[0], a, b,
                   {done, Cout, V, S}, {1'b1, full[8], vx, r});
        end
      end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_add_overflow;
    test_signed_add_overflow;
    test_subtract;
    test_back_to_back;
    test_ignored_start;
    test_reset_mid_op;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
